// File: rtl/uart_rx_ctrl.sv
// Line-configuration holder and receive FIFO for uart_rx; config writes only take effect between frames.
// Optional macro UART_RX_CTRL_IRQ_EN adds a registered irq_o output.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DEF_BAUD   = 16'd9600,
  parameter logic        DEF_PARITY = 1'b0,
  parameter logic        DEF_STOP   = 1'b0,
  localparam int unsigned AW = $clog2(FIFO_DEPTH),
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_we_i,
  input  logic [15:0]   cfg_baud_i,
  input  logic          cfg_parity_en_i,
  input  logic          cfg_stopbit_i,
  output logic          cfg_pending_o,
  input  logic          rx_busy_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic [15:0]   baudrate_o,
  output logic          parity_en_o,
  output logic          stopbit_o,
  output logic [7:0]    rd_data_o,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [CW-1:0] count_o,
  output logic          overflow_o,
  input  logic          ovf_clr_i
`ifdef UART_RX_CTRL_IRQ_EN
  ,
  output logic          irq_o
`endif
);

  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_baud, r_sh_baud;
  logic        r_parity, r_sh_parity;
  logic        r_stop, r_sh_stop;
  logic        w_out_load_new, w_out_load_shadow, w_shadow_load;

  always_comb begin
    w_state_next      = r_state;
    w_out_load_new    = 1'b0;
    w_out_load_shadow = 1'b0;
    w_shadow_load     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_we_i) begin
          if (rx_busy_i) begin
            w_shadow_load = 1'b1;
            w_state_next  = ST_PEND;
          end else begin
            w_out_load_new = 1'b1;
          end
        end
      end
      ST_PEND: begin
        if (!rx_busy_i) begin
          // A write arriving on the release cycle supersedes the held shadow.
          w_state_next = ST_IDLE;
          if (cfg_we_i) w_out_load_new = 1'b1;
          else          w_out_load_shadow = 1'b1;
        end else if (cfg_we_i) begin
          w_shadow_load = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_baud      <= DEF_BAUD;
      r_parity    <= DEF_PARITY;
      r_stop      <= DEF_STOP;
      r_sh_baud   <= DEF_BAUD;
      r_sh_parity <= DEF_PARITY;
      r_sh_stop   <= DEF_STOP;
    end else begin
      r_state <= w_state_next;
      if (w_shadow_load) begin
        r_sh_baud   <= cfg_baud_i;
        r_sh_parity <= cfg_parity_en_i;
        r_sh_stop   <= cfg_stopbit_i;
      end
      if (w_out_load_new) begin
        r_baud   <= cfg_baud_i;
        r_parity <= cfg_parity_en_i;
        r_stop   <= cfg_stopbit_i;
      end else if (w_out_load_shadow) begin
        r_baud   <= r_sh_baud;
        r_parity <= r_sh_parity;
        r_stop   <= r_sh_stop;
      end
    end
  end

  assign cfg_pending_o = (r_state == ST_PEND);
  assign baudrate_o    = r_baud;
  assign parity_en_o   = r_parity;
  assign stopbit_o     = r_stop;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_full, w_pop, w_push, w_drop;

  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = rd_valid_o && rd_ready_i;
  // When full, a simultaneous pop frees the slot the push needs.
  assign w_push = rx_valid_i && (!w_full || w_pop);
  assign w_drop = rx_valid_i && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_overflow <= 1'b1;
      else if (ovf_clr_i) r_overflow <= 1'b0;
    end
  end

  assign rd_data_o  = r_mem[r_rd_ptr];
  assign rd_valid_o = (r_count != '0);
  assign count_o    = r_count;
  assign overflow_o = r_overflow;

`ifdef UART_RX_CTRL_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk_i) begin
    if (!rst_i) r_irq <= 1'b0;
    else        r_irq <= rd_valid_o | r_overflow;
  end
  assign irq_o = r_irq;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Control and buffering block wrapped around `uart_rx`. It owns the receiver's line configuration (baud divider, parity enable, stop-bit length) and applies software writes only between frames, never mid-frame. It captures every completed byte into a FIFO and presents it to the consumer over a valid/ready read port, with a sticky overflow flag.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, ≥ 2.
- `DEF_BAUD`, 16'd9600: `baudrate_o` value after reset; passed to `uart_rx` unchanged.
- `DEF_PARITY`, 1'b0: `parity_en_o` value after reset.
- `DEF_STOP`, 1'b0: `stopbit_o` value after reset.

Ports (CW = $clog2(FIFO_DEPTH)+1):
- `clk_i` in 1: the only clock; all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `cfg_we_i` in 1: configuration write strobe, single cycle.
- `cfg_baud_i` in 16: new baud divider.
- `cfg_parity_en_i` in 1: new parity enable.
- `cfg_stopbit_i` in 1: new stop-bit setting.
- `cfg_pending_o` out 1: a write is held, waiting for the receiver to go idle.
- `rx_busy_i` in 1: from `uart_rx busy_o`.
- `rx_data_i` in 8: from `uart_rx rx_data_o`.
- `rx_valid_i` in 1: from `uart_rx rx_valid_o`; one-cycle pulse per byte.
- `baudrate_o` out 16: to `uart_rx baudrate_i`.
- `parity_en_o` out 1: to `uart_rx parity_en_i`.
- `stopbit_o` out 1: to `uart_rx stopbit_i`.
- `rd_data_o` out 8: FIFO head byte.
- `rd_valid_o` out 1: FIFO non-empty.
- `rd_ready_i` in 1: consumer accepts the head byte.
- `count_o` out CW: FIFO occupancy, 0..FIFO_DEPTH.
- `overflow_o` out 1: sticky; a byte was dropped.
- `ovf_clr_i` in 1: clears `overflow_o`.

## Operation
- Config FSM, two states, IDLE and PEND. All config outputs are registered.
- In IDLE, `cfg_we_i` with `rx_busy_i`=0: the values load into the outputs at that edge. The state stays IDLE.
- In IDLE, `cfg_we_i` with `rx_busy_i`=1: the values load into the shadow registers and the FSM goes to PEND.
- In PEND, `cfg_we_i`: overwrites the shadow registers; the last write wins.
- In PEND, first cycle with `rx_busy_i`=0: the shadow loads into the outputs and the FSM goes to IDLE. If `cfg_we_i` is also high in that cycle, the new write values load directly, not the shadow.
- `cfg_pending_o` = (state == PEND).
- FIFO push: `rx_valid_i`=1 writes `rx_data_i`.
- FIFO pop: `rd_valid_o` & `rd_ready_i`.
- `rd_data_o` = mem[rd_ptr], combinational read of the head.
- `rd_valid_o` = (`count_o` ≠ 0).
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is tracked separately, CW bits wide.
- Full with push and pop in the same cycle: both happen. The count is unchanged and there is no overflow.
- Full with push only: the byte is discarded and the FIFO is unchanged. `overflow_o` sets at that edge.
- `overflow_o` set and `ovf_clr_i` in the same cycle: set wins.
- Empty: no pop can occur. A push to an empty FIFO is readable the next cycle.

## Timing
- Reset values: `baudrate_o`=DEF_BAUD, `parity_en_o`=DEF_PARITY, `stopbit_o`=DEF_STOP, `cfg_pending_o`=0, `count_o`=0, `rd_valid_o`=0, `overflow_o`=0.
- `rd_data_o` is don't-care while `rd_valid_o`=0.
- Reset mid-operation: flushes the FIFO, discards any pending config, and restores the defaults. The config outputs change on the reset edge, even if `uart_rx` is mid-frame.
- Config latency: 1 edge when idle. When pending, 1 edge after the first idle-sampled cycle.
- Receive latency: `rx_valid_i` at edge N gives `rd_valid_o`=1 and the byte on `rd_data_o` after edge N.
- Back-to-back pushes and pops are sustained at 1 byte/cycle.

## Configuration
- Macro: `UART_RX_CTRL_IRQ_EN`.
- Defined: adds output `irq_o` (1 bit), registered, = `rd_valid_o` | `overflow_o` as of the previous edge. Reset value 0.
- Undefined: port `irq_o` does not exist. All other behaviour is identical.

## Test plan
- Reset then idle: outputs equal DEF_BAUD/0/0, `count_o`=0, `rd_valid_o`=0.
- Write baud 16'd115200 (truncated, use 16'd1234), parity 1 with `rx_busy_i`=0 -> `baudrate_o`=1234, `parity_en_o`=1 after one edge, `cfg_pending_o` stays 0.
- Write with `rx_busy_i`=1, then a second write 16'd55 while busy, then busy drops -> `cfg_pending_o`=1 until busy drops; outputs stay old, then become 55 one edge after busy=0.
- Push 0x11..0x18 (DEPTH=8) with `rd_ready_i`=0, then push 0x99 -> `count_o`=8, `overflow_o`=1, 0x99 dropped; reading returns 0x11..0x18 in order, and `rd_valid_o` falls after 0x18.
- FIFO full, push 0xAA and pop in the same cycle -> `count_o` stays 8, no overflow; 0xAA is read last.
- `overflow_o`=1, assert `ovf_clr_i` with a simultaneous overflowing push -> stays 1. Clearing alone on the next cycle -> 0. Reset with 3 bytes queued and a pending config -> `count_o`=0, `cfg_pending_o`=0, defaults restored.
